// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch path.
// Holds the fetch FSM state encoding and the default address/instruction
// widths used by the PC, fetch and decode stages.
package instr_fetch_unit_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DISCARD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's handshake buses.
//   PC side     : PCIn, PCValid (in to unit), PCReady (out), Flush (in)
//   Memory side : MemReq, MemAddr (out), MemAck, MemData (in)
//   Decode side : InstrOut, InstrPC, InstrValid (out), InstrReady (in)
// master = the fetch unit, slave = its environment (PC stage, memory, decoder).
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  PCIn;
  logic               PCValid;
  logic               PCReady;
  logic               Flush;
  logic               MemReq;
  logic [ADDR_W-1:0]  MemAddr;
  logic               MemAck;
  logic [INSTR_W-1:0] MemData;
  logic [INSTR_W-1:0] InstrOut;
  logic [ADDR_W-1:0]  InstrPC;
  logic               InstrValid;
  logic               InstrReady;

  modport master (
    input  PCIn, PCValid, Flush, MemAck, MemData, InstrReady,
    output PCReady, MemReq, MemAddr, InstrOut, InstrPC, InstrValid
  );

  modport slave (
    output PCIn, PCValid, Flush, MemAck, MemData, InstrReady,
    input  PCReady, MemReq, MemAddr, InstrOut, InstrPC, InstrValid
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with synchronous clear, holding {PC, instruction} entries.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset (control only)
//   i_clr            : discard all entries at the next edge (wins over push/pop)
//   i_push, i_push_data : write one entry
//   i_pop            : remove the head entry (ignored when empty)
//   o_pop_data       : head entry, combinational from storage
//   o_empty, o_count : status; count is log2(DEPTH)+1 bits
module fetch_fifo #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_pop_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty && !i_clr;
  assign w_do_push = i_push && (!w_full || w_do_pop) && !i_clr;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts fetch PCs, issues one word read at a time
// over a req/ack memory handshake, and queues {PC, instruction} pairs for the
// decoder. Flush drops everything buffered and any read still in flight.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : master side of instr_fetch_unit_if (PC, memory, decode buses)
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  instr_fetch_unit_if.master   bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DATA_W = ADDR_W + INSTR_W;

  fetch_state_t        r_state;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;

  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic [PTR_W:0]      w_count;
  logic [PTR_W+1:0]    w_credits;
  logic [DATA_W-1:0]   w_head;

  // An in-flight read reserves a FIFO slot, so a returning word always fits.
  assign w_credits = {1'b0, w_count} + (PTR_W+2)'(r_state == ST_WAIT_MEM);

  assign bus.PCReady = !i_rst && (r_state == ST_IDLE) &&
                       (w_credits < (PTR_W+2)'(DEPTH)) && !bus.Flush;
  assign w_accept    = bus.PCValid && bus.PCReady;

  assign w_push = (r_state == ST_WAIT_MEM) && bus.MemAck && !bus.Flush;
  assign w_pop  = !w_empty && bus.InstrReady && !bus.Flush;

  assign bus.MemReq     = r_mem_req;
  assign bus.MemAddr    = r_mem_addr;
  assign bus.InstrValid = !w_empty;
  // Masking keeps the outputs at zero after reset, when storage is unwritten.
  assign bus.InstrOut   = w_empty ? '0 : w_head[INSTR_W-1:0];
  assign bus.InstrPC    = w_empty ? '0 : w_head[DATA_W-1:INSTR_W];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mem_addr <= bus.PCIn;
            r_mem_req  <= 1'b1;
            r_state    <= ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM: begin
          if (bus.MemAck) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (bus.Flush) begin
            r_state   <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          // The memory handshake must complete even though its data is dead.
          if (bus.MemAck) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (bus.Flush),
    .i_push      (w_push),
    .i_push_data ({r_mem_addr, bus.MemData}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference of the fetch behaviour.
module tb_instr_fetch_unit;

  localparam int AW    = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: queue of buffered entries plus the single outstanding read.
  entry_t        q[$];
  bit            m_busy = 0;
  bit            m_drop = 0;
  logic [AW-1:0] m_pc   = '0;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A00_00C3;
  endfunction

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 0;
    m_drop = 0;
  endtask

  function automatic bit exp_ready(input bit fl);
    return !m_busy && (q.size() < DEPTH) && !fl;
  endfunction

  task automatic quiet();
    bus.PCValid = 0; bus.PCIn = '0; bus.Flush = 0;
    bus.InstrReady = 0; bus.MemAck = 0; bus.MemData = '0;
    #1;
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model.
  task automatic cycle(input bit pcv, input logic [AW-1:0] pc, input bit fl,
                       input bit rdy, input bit ack, input logic [IW-1:0] data);
    bit     acc;
    bit     ackd;
    entry_t e;
    bus.PCValid = pcv; bus.PCIn = pc; bus.Flush = fl;
    bus.InstrReady = rdy; bus.MemAck = ack && m_busy; bus.MemData = data;
    #1;
    check("pcready", AW'(bus.PCReady), AW'(exp_ready(fl)));
    check("memreq", AW'(bus.MemReq), AW'(m_busy));
    if (m_busy) check("memaddr", bus.MemAddr, m_pc);
    check("instr_valid", AW'(bus.InstrValid), AW'(q.size() != 0));
    if (q.size() != 0) begin
      check("instr_out", AW'(bus.InstrOut), AW'(q[0].instr));
      check("instr_pc", bus.InstrPC, q[0].pc);
    end
    acc  = pcv && exp_ready(fl);
    ackd = ack && m_busy;
    if (fl) begin
      q.delete();
      if (m_busy) begin
        if (ackd) m_busy = 0;
        else      m_drop = 1;
      end
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (ackd) begin
        if (!m_drop) begin
          e.pc = m_pc; e.instr = data;
          q.push_back(e);
        end
        m_busy = 0;
      end
    end
    if (acc) begin
      m_busy = 1; m_drop = 0; m_pc = pc;
    end
    @(negedge clk);
  endtask

  // Present a PC until accepted; memory acks any pending read meanwhile.
  task automatic issue(input logic [AW-1:0] pc, input bit rdy);
    int tries = 0;
    bit done  = 0;
    while (!done && tries < 20) begin
      done = exp_ready(0);
      cycle(1, pc, 0, rdy, 1, mem_word(m_pc));
      tries++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $error("FAIL issue_timeout: pc %h never accepted", pc);
    end
  endtask

  logic [AW-1:0] order [4];

  initial begin
    quiet();
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_memreq", AW'(bus.MemReq), '0);
    check("rst_memaddr", bus.MemAddr, '0);
    check("rst_valid", AW'(bus.InstrValid), '0);
    check("rst_instr", AW'(bus.InstrOut), '0);
    check("rst_pc", bus.InstrPC, '0);
    check("rst_pcready", AW'(bus.PCReady), '0);
    rst = 0;
    @(negedge clk);

    // Basic fetch
    issue(64'h10, 0);
    cycle(0, '0, 0, 0, 0, '0);
    cycle(0, '0, 0, 0, 1, 32'h8B02_0020);
    check("basic_valid", AW'(bus.InstrValid), 64'd1);
    check("basic_instr", AW'(bus.InstrOut), 64'h8B02_0020);
    check("basic_pc", bus.InstrPC, 64'h10);
    cycle(0, '0, 0, 1, 0, '0);

    // Backpressure until full, then one pop frees a slot
    issue(64'h0, 0); issue(64'h4, 0); issue(64'h8, 0); issue(64'hC, 0);
    repeat (3) cycle(1, 64'h10, 0, 0, 1, mem_word(m_pc));
    check("full_pcready", AW'(bus.PCReady), '0);
    cycle(1, 64'h10, 0, 1, 1, '0);
    issue(64'h10, 0);
    order[0] = 64'h4; order[1] = 64'h8; order[2] = 64'hC; order[3] = 64'h10;
    for (int k = 0; k < 4; k++) begin
      check("order_pc", bus.InstrPC, order[k]);
      cycle(0, '0, 0, 1, 1, mem_word(m_pc));
    end

    // Flush while a read is in flight
    issue(64'h20, 1);
    cycle(0, '0, 1, 1, 0, '0);
    cycle(1, 64'h24, 0, 1, 0, '0);
    cycle(1, 64'h24, 0, 1, 0, '0);
    check("discard_memreq", AW'(bus.MemReq), 64'd1);
    cycle(1, 64'h24, 0, 1, 1, 32'h0000_DEAD);
    check("discard_valid", AW'(bus.InstrValid), '0);
    check("discard_pcready", AW'(bus.PCReady), 64'd1);

    // Flush coinciding with an ack while two entries are buffered
    issue(64'h28, 0); issue(64'h2C, 0); issue(64'h30, 0);
    cycle(0, '0, 1, 0, 1, mem_word(64'h30));
    quiet();
    check("flushack_valid", AW'(bus.InstrValid), '0);
    check("flushack_pcready", AW'(bus.PCReady), 64'd1);
    check("flushack_memreq", AW'(bus.MemReq), '0);

    // Push and pop in the same cycle
    issue(64'h40, 0);
    cycle(0, '0, 0, 0, 1, mem_word(64'h40));
    issue(64'h44, 0);
    cycle(0, '0, 0, 1, 1, 32'h1234_5678);
    check("pushpop_valid", AW'(bus.InstrValid), 64'd1);
    check("pushpop_pc", bus.InstrPC, 64'h44);
    check("pushpop_instr", AW'(bus.InstrOut), 64'h1234_5678);
    cycle(0, '0, 0, 1, 0, '0);

    // Asynchronous reset between edges during a pending read
    issue(64'h4C, 0);
    cycle(0, '0, 0, 0, 1, mem_word(64'h4C));
    issue(64'h50, 0);
    #2 rst = 1;
    #1;
    check("arst_memreq", AW'(bus.MemReq), '0);
    check("arst_valid", AW'(bus.InstrValid), '0);
    check("arst_pcready", AW'(bus.PCReady), '0);
    model_reset();
    @(negedge clk);
    rst = 0;
    cycle(0, '0, 0, 0, 0, '0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0,
            {$urandom(), $urandom()} & ~64'h3,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1,
            mem_word(m_pc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
